// File: rtl/cpu_regs_bank.sv
// cpu_regs_bank: parametrised CPU register bank behind the cpu_sync IP bus.
// Provides ID/VERSION words, NUM_RW byte-enabled R/W registers, NUM_RO sampled
// status inputs and NUM_CNT clear-on-read event counters with a coherent
// high-word snapshot.
// Optional build macro: CPU_REGS_BANK_CNT_SATURATE_EN. When it is defined,
// counters saturate at all-ones instead of wrapping.
module cpu_regs_bank #(
    parameter int unsigned ADDR_WIDTH    = 12,
    parameter int unsigned NUM_RW        = 4,
    parameter int unsigned NUM_RO        = 2,
    parameter int unsigned NUM_CNT       = 4,
    parameter int unsigned CNT_WIDTH     = 48,
    parameter logic [31:0] ID_VALUE      = 32'h0000_DA01,
    parameter logic [31:0] VERSION_VALUE = 32'h0000_0001,
    parameter logic [31:0] RW_DEFAULT    = 32'h0
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    bus2ip_cs,
    input  logic                    bus2ip_rnw,
    input  logic [ADDR_WIDTH-1:0]   bus2ip_addr,
    input  logic [31:0]             bus2ip_data,
    input  logic [3:0]              bus2ip_be,
    output logic [31:0]             ip2bus_data,
    output logic                    ip2bus_rdack,
    output logic                    ip2bus_wrack,
    output logic                    ip2bus_error,
    output logic [NUM_RW*32-1:0]    rw_regs,
    input  logic [NUM_RO*32-1:0]    ro_regs,
    input  logic [NUM_CNT-1:0]      cnt_inc,
    output logic [NUM_CNT-1:0]      cnt_ovf
);

    localparam logic [31:0] DEAD_WORD = 32'hDEAD_BEEF;
    localparam logic [31:0] ADDR_ID   = 32'h000;
    localparam logic [31:0] ADDR_VER  = 32'h004;
    localparam logic [31:0] BASE_RW   = 32'h040;
    localparam logic [31:0] BASE_RO   = 32'h080;
    localparam logic [31:0] BASE_CNT  = 32'h100;

    // ------------------------------------------------------------------
    // Handshake state
    // ------------------------------------------------------------------
    logic        armed_q, armed_d;
    logic        rdack_q, wrack_q;
    logic [31:0] data_q;
    logic        error_q;

    logic        accept;
    logic        rd_accept;
    logic        wr_accept;

    assign accept    = bus2ip_cs & armed_q;
    assign rd_accept = accept & bus2ip_rnw;
    assign wr_accept = accept & ~bus2ip_rnw;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [31:0]              addr_ext;
    logic                     mapped;
    logic [31:0]              rd_data;
    logic [NUM_RW-1:0]        rw_hit;
    logic [NUM_CNT-1:0]       lo_hit;

    logic [31:0]              rw_q [NUM_RW];
    logic [31:0]              rw_d [NUM_RW];
    logic [NUM_CNT-1:0][31:0] cnt_lo;
    logic [NUM_CNT-1:0][31:0] cnt_hi;

    assign addr_ext = 32'(bus2ip_addr);

    // Decode the byte address into a hit vector and the read-data value.
    always_comb begin
        rd_data = DEAD_WORD;
        mapped  = 1'b0;
        rw_hit  = '0;
        lo_hit  = '0;

        if (addr_ext == ADDR_ID) begin
            rd_data = ID_VALUE;
            mapped  = 1'b1;
        end
        if (addr_ext == ADDR_VER) begin
            rd_data = VERSION_VALUE;
            mapped  = 1'b1;
        end
        for (int i = 0; i < NUM_RW; i++) begin
            if (addr_ext == BASE_RW + 32'(4 * i)) begin
                rw_hit[i] = 1'b1;
                rd_data   = rw_q[i];
                mapped    = 1'b1;
            end
        end
        for (int j = 0; j < NUM_RO; j++) begin
            if (addr_ext == BASE_RO + 32'(4 * j)) begin
                rd_data = ro_regs[32*j +: 32];
                mapped  = 1'b1;
            end
        end
        for (int k = 0; k < NUM_CNT; k++) begin
            if (addr_ext == BASE_CNT + 32'(8 * k)) begin
                lo_hit[k] = 1'b1;
                rd_data   = cnt_lo[k];
                mapped    = 1'b1;
            end
            if (addr_ext == BASE_CNT + 32'(8 * k + 4)) begin
                rd_data = cnt_hi[k];
                mapped  = 1'b1;
            end
        end
    end

    // Re-arm on the first idle cycle after an accepted access.
    always_comb begin
        armed_d = armed_q;
        if (accept) begin
            armed_d = 1'b0;
        end else if (!bus2ip_cs) begin
            armed_d = 1'b1;
        end
    end

    // Handshake, acknowledge and response registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            armed_q <= 1'b1;
            rdack_q <= 1'b0;
            wrack_q <= 1'b0;
            data_q  <= DEAD_WORD;
            error_q <= 1'b0;
        end else begin
            armed_q <= armed_d;
            rdack_q <= rd_accept;
            wrack_q <= wr_accept;
            if (rd_accept) begin
                data_q <= rd_data;
            end
            if (accept) begin
                error_q <= ~mapped;
            end
        end
    end

    assign ip2bus_data  = data_q;
    assign ip2bus_rdack = rdack_q;
    assign ip2bus_wrack = wrack_q;
    assign ip2bus_error = error_q;

    // ------------------------------------------------------------------
    // R/W registers
    // ------------------------------------------------------------------
    // Byte-enabled write into the addressed R/W register.
    always_comb begin
        for (int i = 0; i < NUM_RW; i++) begin
            rw_d[i] = rw_q[i];
            if (wr_accept && rw_hit[i]) begin
                for (int b = 0; b < 4; b++) begin
                    if (bus2ip_be[b]) begin
                        rw_d[i][8*b +: 8] = bus2ip_data[8*b +: 8];
                    end
                end
            end
        end
    end

    // R/W register storage.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_RW; i++) begin
                rw_q[i] <= RW_DEFAULT;
            end
        end else begin
            for (int i = 0; i < NUM_RW; i++) begin
                rw_q[i] <= rw_d[i];
            end
        end
    end

    // Flatten R/W registers onto the output bus.
    always_comb begin
        rw_regs = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            rw_regs[32*i +: 32] = rw_q[i];
        end
    end

    // ------------------------------------------------------------------
    // Event counters
    // ------------------------------------------------------------------
    for (genvar k = 0; k < NUM_CNT; k++) begin : gen_cnt
        logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
        logic [31:0]          snap_q, snap_d;
        logic                 ovf_q, ovf_d;
        logic                 clr;
        logic                 ovf_set;
        logic [63:0]          cnt_ext;

        // Low-word read clears the counter and captures its upper word.
        assign clr     = rd_accept & lo_hit[k];
        assign cnt_ext = 64'(cnt_q);

        // Next count; a clear with a coincident event restarts at 1 so no
        // event is lost.
        always_comb begin
`ifdef CPU_REGS_BANK_CNT_SATURATE_EN
            if (clr) begin
                cnt_d = CNT_WIDTH'(cnt_inc[k]);
            end else if (cnt_q == '1) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(cnt_inc[k]);
            end
            ovf_set = cnt_inc[k] & (cnt_d == '1);
`else
            if (clr) begin
                cnt_d = CNT_WIDTH'(cnt_inc[k]);
            end else begin
                cnt_d = cnt_q + CNT_WIDTH'(cnt_inc[k]);
            end
            ovf_set = cnt_inc[k] & (cnt_q == '1);
`endif
            snap_d = clr ? cnt_ext[63:32] : snap_q;
            // A wrap in the clearing cycle keeps the flag set.
            ovf_d  = ovf_set | (ovf_q & ~clr);
        end

        // Counter, snapshot and sticky overflow storage.
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                cnt_q  <= '0;
                snap_q <= '0;
                ovf_q  <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                snap_q <= snap_d;
                ovf_q  <= ovf_d;
            end
        end

        assign cnt_lo[k]  = cnt_ext[31:0];
        assign cnt_hi[k]  = snap_q;
        assign cnt_ovf[k] = ovf_q;
    end

endmodule

// File: tb/tb_cpu_regs_bank.sv
// Directed self-checking bench for cpu_regs_bank (default parameters).
module tb_cpu_regs_bank;

    logic         clk = 1'b0;
    logic         resetn;
    logic         bus2ip_cs;
    logic         bus2ip_rnw;
    logic [11:0]  bus2ip_addr;
    logic [31:0]  bus2ip_data;
    logic [3:0]   bus2ip_be;
    logic [31:0]  ip2bus_data;
    logic         ip2bus_rdack;
    logic         ip2bus_wrack;
    logic         ip2bus_error;
    logic [127:0] rw_regs;
    logic [63:0]  ro_regs;
    logic [3:0]   cnt_inc;
    logic [3:0]   cnt_ovf;

    int tests = 0;
    int fails = 0;

    logic [31:0] rd;
    logic        er;
    int          na;

    always #5 clk = ~clk;

    cpu_regs_bank dut (
        .clk          (clk),
        .resetn       (resetn),
        .bus2ip_cs    (bus2ip_cs),
        .bus2ip_rnw   (bus2ip_rnw),
        .bus2ip_addr  (bus2ip_addr),
        .bus2ip_data  (bus2ip_data),
        .bus2ip_be    (bus2ip_be),
        .ip2bus_data  (ip2bus_data),
        .ip2bus_rdack (ip2bus_rdack),
        .ip2bus_wrack (ip2bus_wrack),
        .ip2bus_error (ip2bus_error),
        .rw_regs      (rw_regs),
        .ro_regs      (ro_regs),
        .cnt_inc      (cnt_inc),
        .cnt_ovf      (cnt_ovf)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus access with cs held for 'hold' cycles, then one idle cycle.
    // Wrong-type acks add 100 to the count so they cannot go unnoticed.
    task automatic access(input logic rnw, input logic [11:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int hold,
                          output logic [31:0] data, output logic err, output int acks);
        data        = 32'h0;
        err         = 1'b0;
        acks        = 0;
        bus2ip_cs   = 1'b1;
        bus2ip_rnw  = rnw;
        bus2ip_addr = addr;
        bus2ip_data = wdata;
        bus2ip_be   = be;
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            if (rnw ? ip2bus_rdack : ip2bus_wrack) begin
                acks++;
                data = ip2bus_data;
                err  = ip2bus_error;
            end
            if (rnw ? ip2bus_wrack : ip2bus_rdack) begin
                acks += 100;
            end
        end
        bus2ip_cs = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd32(input logic [11:0] addr, output logic [31:0] data, output logic err,
                        output int acks);
        access(1'b1, addr, 32'h0, 4'h0, 3, data, err, acks);
    endtask

    initial begin
        resetn      = 1'b0;
        bus2ip_cs   = 1'b0;
        bus2ip_rnw  = 1'b1;
        bus2ip_addr = '0;
        bus2ip_data = '0;
        bus2ip_be   = '0;
        ro_regs     = {32'hCAFE_0002, 32'h1234_5678};
        cnt_inc     = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_data", ip2bus_data, 32'hDEAD_BEEF);
        check("rst_acks", {ip2bus_rdack, ip2bus_wrack, ip2bus_error}, 3'b000);
        check("rst_rw", rw_regs[127:64], 64'h0);
        check("rst_rw_lo", rw_regs[63:0], 64'h0);
        check("rst_ovf", cnt_ovf, 4'h0);
        resetn = 1'b1;
        @(negedge clk);

        // ID / VERSION
        rd32(12'h000, rd, er, na);
        check("id_data", rd, 32'h0000_DA01);
        check("id_err", er, 1'b0);
        check("id_acks", na, 1);
        rd32(12'h004, rd, er, na);
        check("ver_data", rd, 32'h0000_0001);

        // Byte-enabled write, cs held 5 cycles
        access(1'b0, 12'h044, 32'hAABB_CCDD, 4'b0101, 5, rd, er, na);
        check("wr1_acks", na, 1);
        check("wr1_err", er, 1'b0);
        check("wr1_reg1", rw_regs[63:32], 32'h00BB_00DD);
        check("wr1_others", {rw_regs[127:64], rw_regs[31:0]}, 64'h0);
        rd32(12'h044, rd, er, na);
        check("rd_reg1", rd, 32'h00BB_00DD);

        access(1'b0, 12'h048, 32'h1122_3344, 4'b1110, 3, rd, er, na);
        access(1'b0, 12'h048, 32'h0000_00FF, 4'b0001, 3, rd, er, na);
        check("wr_reg2", rw_regs[95:64], 32'h1122_33FF);

        // RO inputs sampled at read
        rd32(12'h080, rd, er, na);
        check("ro0", rd, 32'h1234_5678);
        rd32(12'h084, rd, er, na);
        check("ro1", rd, 32'hCAFE_0002);
        ro_regs[31:0] = 32'h0BAD_F00D;
        rd32(12'h080, rd, er, na);
        check("ro0_new", rd, 32'h0BAD_F00D);

        // Write to ID: acked, no effect, no error
        access(1'b0, 12'h000, 32'hFFFF_FFFF, 4'hF, 3, rd, er, na);
        check("wr_id_err", {na[7:0], er}, {8'd1, 1'b0});
        rd32(12'h000, rd, er, na);
        check("id_kept", rd, 32'h0000_DA01);

        // Counter 1: ten events
        cnt_inc = 4'b0010;
        repeat (10) @(negedge clk);
        cnt_inc = 4'b0000;
        rd32(12'h108, rd, er, na);
        check("c1_lo", rd, 32'd10);
        rd32(12'h10C, rd, er, na);
        check("c1_hi", rd, 32'd0);
        rd32(12'h108, rd, er, na);
        check("c1_cleared", rd, 32'd0);

        // Counter 2: preload 2^40+5, coherent high snapshot
        force dut.gen_cnt[2].cnt_q = 48'h0100_0000_0005;
        @(negedge clk);
        release dut.gen_cnt[2].cnt_q;
        @(negedge clk);
        rd32(12'h110, rd, er, na);
        check("c2_lo", rd, 32'd5);
        cnt_inc = 4'b0100;
        repeat (3) @(negedge clk);
        cnt_inc = 4'b0000;
        rd32(12'h114, rd, er, na);
        check("c2_hi_snap", rd, 32'h0000_0100);
        rd32(12'h110, rd, er, na);
        check("c2_lo_after", rd, 32'd3);
        rd32(12'h114, rd, er, na);
        check("c2_hi_new", rd, 32'd0);

        // Counter 0: continuous increments, clear-on-read loses nothing
        cnt_inc = 4'b0001;
        repeat (20) @(negedge clk);
        rd32(12'h100, rd, er, na);
        check("c0_first", rd, 32'd20);
        rd32(12'h100, rd, er, na);
        check("c0_second", rd, 32'd4);
        cnt_inc = 4'b0000;

        // Counter 3: wrap from all-ones sets sticky overflow; low read clears it
        force dut.gen_cnt[3].cnt_q = 48'hFFFF_FFFF_FFFF;
        @(negedge clk);
        release dut.gen_cnt[3].cnt_q;
        cnt_inc = 4'b1000;
        @(negedge clk);
        cnt_inc = 4'b0000;
        check("c3_ovf_set", cnt_ovf, 4'b1000);
        rd32(12'h118, rd, er, na);
        check("c3_wrapped", rd, 32'd0);
        check("c3_ovf_clr", cnt_ovf, 4'b0000);

        // Unmapped read and write
        rd32(12'h3FC, rd, er, na);
        check("unm_rd_data", rd, 32'hDEAD_BEEF);
        check("unm_rd_err", er, 1'b1);
        access(1'b0, 12'h3FC, 32'hFFFF_FFFF, 4'hF, 3, rd, er, na);
        check("unm_wr_ack_err", {na[7:0], er}, {8'd1, 1'b1});
        check("unm_wr_regs_hi", rw_regs[127:64], 64'h0000_0000_1122_33FF);
        check("unm_wr_regs_lo", rw_regs[63:0], 64'h00BB_00DD_0000_0000);

        // Reset asserted while cs is high
        bus2ip_cs   = 1'b1;
        bus2ip_rnw  = 1'b0;
        bus2ip_addr = 12'h040;
        bus2ip_data = 32'hFFFF_FFFF;
        bus2ip_be   = 4'hF;
        resetn      = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_acks", {ip2bus_rdack, ip2bus_wrack}, 2'b00);
        check("mid_rst_rw", rw_regs[127:64] | rw_regs[63:0], 64'h0);
        check("mid_rst_data", ip2bus_data, 32'hDEAD_BEEF);
        bus2ip_cs = 1'b0;
        resetn    = 1'b1;
        @(negedge clk);
        rd32(12'h040, rd, er, na);
        check("post_rst_reg0", rd, 32'h0);
        rd32(12'h104, rd, er, na);
        check("post_rst_snap0", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_regs_bank.md
Name: cpu_regs_bank

Overview:
- Parametrised successor of the per-project generated CPU register file.
- Sits behind the cpu_sync IP-clock-domain bus (bus2ip_*/ip2bus_*) and provides fixed ID/version words, N generic R/W control registers with byte enables, M generic read-only status inputs, and K internal event counters.
- Counters are clear-on-read, up to 64 bits wide, with a coherent high-word snapshot.
- Removes per-project hand-generation of counter/clear plumbing.

Parameters:
- ADDR_WIDTH, 12, bus2ip_addr width (byte address, word aligned).
- NUM_RW, 4, number of 32-bit R/W registers (1..16).
- NUM_RO, 2, number of 32-bit read-only status inputs (1..16).
- NUM_CNT, 4, number of event counters (1..32).
- CNT_WIDTH, 48, counter width (1..64).
- ID_VALUE, 32'h0000_DA01, value returned at ID.
- VERSION_VALUE, 32'h0000_0001, value returned at VERSION.
- RW_DEFAULT, 32'h0, reset value of every R/W register.

Ports:
- clk  in  1  IP clock
- resetn  in  1  asynchronous active-low reset
- bus2ip_cs  in  1  access request, held high until ack seen
- bus2ip_rnw  in  1  1=read, 0=write
- bus2ip_addr  in  ADDR_WIDTH  byte address
- bus2ip_data  in  32  write data
- bus2ip_be  in  4  write byte enables
- ip2bus_data  out  32  read data
- ip2bus_rdack  out  1  read acknowledge pulse
- ip2bus_wrack  out  1  write acknowledge pulse
- ip2bus_error  out  1  unmapped-address flag, valid with ack
- rw_regs  out  NUM_RW*32  R/W register contents, reg i at [32i+31:32i]
- ro_regs  in  NUM_RO*32  status inputs, sampled at read
- cnt_inc  in  NUM_CNT  per-counter increment strobe, +1 per high cycle
- cnt_ovf  out  NUM_CNT  sticky overflow flag per counter

Behaviour:
- Clock and reset:
  - Single clock.
  - resetn asynchronous assert, synchronous deassert by the parent.
  - All flops are cleared on reset: ip2bus_data=32'hDEADBEEF, acks=0, error=0, rw_regs=RW_DEFAULT, counters=0, snapshots=0, cnt_ovf=0, armed=1.
- Address map (byte offsets):
  - 0x000 ID.
  - 0x004 VERSION.
  - 0x040+4i R/W reg i.
  - 0x080+4j RO input j.
  - 0x100+8k counter k low word.
  - 0x104+8k counter k high word.
  - Anything else is unmapped.
- Handshake:
  - Internal `armed` flag.
  - An access is accepted on a cycle with cs=1 and armed=1. armed clears on acceptance and sets again on the first cycle with cs=0.
  - Exactly one ack per cs assertion, one cycle after acceptance: rdack if rnw=1, else wrack.
  - ip2bus_data and ip2bus_error are valid in the rdack/wrack cycle and hold until the next acceptance.
  - Latency is 1 cycle, fixed.
- Reads:
  - ID/VERSION/RW/RO return their value. RO is sampled in the acceptance cycle.
  - Counter low word returns cnt[31:0] (zero-extended if CNT_WIDTH<32). In the same cycle it latches snap_k = cnt[CNT_WIDTH-1:32] (0 if CNT_WIDTH≤32) and clears the counter.
  - Counter high word returns snap_k, not the live value. It has no side effect.
  - Unmapped reads return 32'hDEADBEEF with error=1.
- Writes:
  - R/W reg i updates byte b only when be[b]=1.
  - Writes to ID, VERSION, RO and counter addresses are acked with no effect and error=0.
  - Unmapped writes are acked with error=1.
- Counters:
  - Add cnt_inc[k] each cycle, modulo 2^CNT_WIDTH.
  - Wrap from all-ones sets cnt_ovf[k].
  - cnt_ovf[k] clears on a low-word read of counter k, unless a wrap occurs in that same cycle.
  - Clear-on-read coincident with cnt_inc[k]=1: the returned value excludes that event and the counter becomes 1. No event is lost.
- Reset mid-access: acks drop immediately and no write takes effect. The master re-issues.

Optional Feature:
- Macro CPU_REGS_BANK_CNT_SATURATE_EN.
- When defined:
  - Counters saturate at all-ones instead of wrapping.
  - cnt_ovf[k] sets on reaching saturation.
  - A clear-on-read with coincident increment still yields 1.
- When undefined: modulo wrap as above.

Test Plan:
- After reset → read 0x000 gives 32'h0000_DA01 with one rdack and error=0. Read 0x004 gives 32'h1. rw_regs all 0.
- Write 0x044 data 32'hAABBCCDD be=4'b0101, then read 0x044 → 32'h00BB00DD. rw_regs[63:32]=32'h00BB00DD. Exactly one wrack while cs held 5 cycles.
- Pulse cnt_inc[1] 10 cycles, read 0x108 → 10. Read 0x10C → 0. Read 0x108 again → 0.
- Preload counter 2 to 2^40+5 via 2^40+5 increments (or force in bench), read 0x110 → 5 and 0x114 → 32'h100. Increments between the two reads do not change 0x114.
- Hold cnt_inc[0]=1 continuously, read 0x100 at cycle 20 → value N, next read returns exactly the cycles since the first read. No lost count.
- Read 0x3FC → 32'hDEADBEEF with error=1. Write 0x3FC → wrack, error=1, no register change. Assert resetn=0 during cs → acks 0, state reset.
